// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
// Mode controller and MM:SS time-keeping sequencer for the lab stopwatch.
//
// Build option:
//   STOPWATCH_LAP_EN - adds lap_pulse; toggles a lap hold that freezes the
//                      displayed MM:SS while internal counting continues.
//
// Parameters:
//   MAX_MIN   highest minutes value before wrap to 00 (1..99)
//   SEC_WRAP  highest seconds value before wrap to 00 (59 in normal use)
//
// Ports:
//   clk, rst       clock, synchronous active-high reset
//   tick_normal    1 Hz enable, counts in RUN
//   tick_adjust    2 Hz enable, increments the selected field in ADJ
//   tick_blink     blink enable, toggles blink phase in ADJ
//   pause_pulse    toggles run/pause
//   adj, sel       adjust mode level; field select (0 min, 1 sec)
//   lap_pulse      lap hold toggle (STOPWATCH_LAP_EN only)
//   pause_out      to divider pause input, 1 only in PAUSED
//   min_bcd        minutes BCD {tens, ones}
//   sec_bcd        seconds BCD {tens, ones}
//   blank_min/sec  display blanking for the field being adjusted
//   mode           00 RUN, 01 PAUSED, 10 ADJ
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
   parameter int MAX_MIN  = 59,
   parameter int SEC_WRAP = 59
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       tick_normal,
   input  logic       tick_adjust,
   input  logic       tick_blink,
   input  logic       pause_pulse,
   input  logic       adj,
   input  logic       sel,
`ifdef STOPWATCH_LAP_EN
   input  logic       lap_pulse,
`endif
   output logic       pause_out,
   output logic [7:0] min_bcd,
   output logic [7:0] sec_bcd,
   output logic       blank_min,
   output logic       blank_sec,
   output logic [1:0] mode
);

   typedef enum logic [1:0] {RUN = 2'b00, PAUSED = 2'b01, ADJ = 2'b10} state_t;

   localparam logic [7:0] MIN_TOP = {4'(MAX_MIN / 10), 4'(MAX_MIN % 10)};
   localparam logic [7:0] SEC_TOP = {4'(SEC_WRAP / 10), 4'(SEC_WRAP % 10)};

   // BCD increment with wrap at top; result is {wrapped, next_value}.
   // Digit-wise so no binary intermediate ever exists.
   function automatic logic [8:0] bcd_inc(input logic [7:0] v, input logic [7:0] top);
      if (v == top)
         return {1'b1, 8'h00};
      else if (v[3:0] == 4'd9)
         return {1'b0, v[7:4] + 4'd1, 4'd0};
      else
         return {1'b0, v[7:4], v[3:0] + 4'd1};
   endfunction

   state_t     state, state_nx;
   logic       paused, paused_nx;
   logic       blink_phase, blink_nx;
   logic [7:0] min_q, min_nx;
   logic [7:0] sec_q, sec_nx;
   logic [8:0] min_inc, sec_inc;

   // ---------------------------------------------------------------------------
   // Next-state, counting and blink logic. Counting keys off the state at the
   // start of the cycle, so a tick coincident with a mode change still lands.
   // ---------------------------------------------------------------------------
   always_comb begin
      state_nx  = state;
      paused_nx = paused;
      blink_nx  = blink_phase;
      min_nx    = min_q;
      sec_nx    = sec_q;
      min_inc   = bcd_inc(min_q, MIN_TOP);
      sec_inc   = bcd_inc(sec_q, SEC_TOP);

      case (state)
         RUN: begin
            if (tick_normal) begin
               sec_nx = sec_inc[7:0];
               if (sec_inc[8])
                  min_nx = min_inc[7:0];
            end
         end
         ADJ: begin
            // Fields adjust independently: no carry from seconds into minutes.
            if (tick_adjust) begin
               if (sel)
                  sec_nx = sec_inc[7:0];
               else
                  min_nx = min_inc[7:0];
            end
         end
         default: ;
      endcase

      if (adj) begin
         state_nx = ADJ;
         if (state != ADJ) begin
            blink_nx = 1'b0;
         end else begin
            if (tick_blink)
               blink_nx = ~blink_phase;
            // In ADJ a pause press only arms the mode to return to.
            if (pause_pulse)
               paused_nx = ~paused;
         end
      end else if (state == ADJ) begin
         state_nx = paused ? PAUSED : RUN;
      end else if (pause_pulse) begin
         state_nx  = (state == RUN) ? PAUSED : RUN;
         paused_nx = (state == RUN);
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RUN;
         paused      <= 1'b0;
         blink_phase <= 1'b0;
         min_q       <= 8'h00;
         sec_q       <= 8'h00;
         pause_out   <= 1'b0;
         blank_min   <= 1'b0;
         blank_sec   <= 1'b0;
      end else begin
         state       <= state_nx;
         paused      <= paused_nx;
         blink_phase <= blink_nx;
         min_q       <= min_nx;
         sec_q       <= sec_nx;
         // ADJ keeps pause_out low so the divider keeps generating tick_adjust.
         pause_out   <= (state_nx == PAUSED);
         blank_min   <= (state_nx == ADJ) & ~sel & blink_nx;
         blank_sec   <= (state_nx == ADJ) &  sel & blink_nx;
      end
   end

   assign mode = state;

`ifdef STOPWATCH_LAP_EN
   // ---------------------------------------------------------------------------
   // Lap hold: display shows a snapshot taken when the hold is set, while
   // min_q/sec_q keep counting underneath.
   // ---------------------------------------------------------------------------
   logic       lap_hold, lap_nx;
   logic [7:0] snap_min, snap_min_nx;
   logic [7:0] snap_sec, snap_sec_nx;

   always_comb begin
      lap_nx      = lap_hold;
      snap_min_nx = snap_min;
      snap_sec_nx = snap_sec;
      if (state_nx == ADJ) begin
         lap_nx = 1'b0;
      end else if (state != ADJ && lap_pulse) begin
         lap_nx = ~lap_hold;
         if (!lap_hold) begin
            snap_min_nx = min_q;
            snap_sec_nx = sec_q;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         lap_hold <= 1'b0;
         snap_min <= 8'h00;
         snap_sec <= 8'h00;
         min_bcd  <= 8'h00;
         sec_bcd  <= 8'h00;
      end else begin
         lap_hold <= lap_nx;
         snap_min <= snap_min_nx;
         snap_sec <= snap_sec_nx;
         min_bcd  <= lap_nx ? snap_min_nx : min_nx;
         sec_bcd  <= lap_nx ? snap_sec_nx : sec_nx;
      end
   end
`else
   assign min_bcd = min_q;
   assign sec_bcd = sec_q;
`endif

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// tb_stopwatch_ctrl
// Self-checking bench for stopwatch_ctrl. Directed scenarios plus a random
// run, all checked against a decimal minutes/seconds model of the stopwatch.
// -----------------------------------------------------------------------------
module tb_stopwatch_ctrl;

   localparam int MAX_MIN  = 59;
   localparam int SEC_WRAP = 59;
`ifdef STOPWATCH_LAP_EN
   localparam bit LAP_EN = 1'b1;
`else
   localparam bit LAP_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       tick_normal = 1'b0, tick_adjust = 1'b0, tick_blink = 1'b0;
   logic       pause_pulse = 1'b0, adj = 1'b0, sel = 1'b0, lap_pulse = 1'b0;
   logic       pause_out, blank_min, blank_sec;
   logic [7:0] min_bcd, sec_bcd;
   logic [1:0] mode;

   int errors = 0;
   int checks = 0;

   stopwatch_ctrl #(.MAX_MIN(MAX_MIN), .SEC_WRAP(SEC_WRAP)) dut (
      .clk(clk), .rst(rst),
      .tick_normal(tick_normal), .tick_adjust(tick_adjust), .tick_blink(tick_blink),
      .pause_pulse(pause_pulse), .adj(adj), .sel(sel),
`ifdef STOPWATCH_LAP_EN
      .lap_pulse(lap_pulse),
`endif
      .pause_out(pause_out), .min_bcd(min_bcd), .sec_bcd(sec_bcd),
      .blank_min(blank_min), .blank_sec(blank_sec), .mode(mode)
   );

   always #5 clk = ~clk;

   // ---- reference model: plain decimal time, mode as 0/1/2 -------------------
   int m_min = 0, m_sec = 0, m_mode = 0, m_paused = 0, m_blink = 0;
   int m_lap = 0, m_snap_min = 0, m_snap_sec = 0;
   int m_sel = 0;

   function automatic logic [7:0] to_bcd(input int v);
      logic [7:0] r;
      r = {4'(v / 10), 4'(v % 10)};
      return r;
   endfunction

   function automatic logic [20:0] exp_vec();
      logic [1:0] md;
      logic       po, bm, bs;
      md = 2'(m_mode);
      po = (m_mode == 1);
      bm = (m_mode == 2) && (m_sel == 0) && (m_blink != 0);
      bs = (m_mode == 2) && (m_sel == 1) && (m_blink != 0);
      if (m_lap != 0)
         return {md, po, bm, bs, to_bcd(m_snap_min), to_bcd(m_snap_sec)};
      return {md, po, bm, bs, to_bcd(m_min), to_bcd(m_sec)};
   endfunction

   task automatic model_step(input bit tn, ta, tb, pp, a, s, r, lp);
      int old, nm, pmin, psec;
      m_sel = s;
      if (r) begin
         m_min = 0; m_sec = 0; m_mode = 0; m_paused = 0; m_blink = 0; m_lap = 0;
         return;
      end
      old = m_mode; pmin = m_min; psec = m_sec;
      if (old == 0 && tn) begin
         m_sec = m_sec + 1;
         if (m_sec > SEC_WRAP) begin
            m_sec = 0;
            m_min = (m_min + 1) % (MAX_MIN + 1);
         end
      end
      if (old == 2 && ta) begin
         if (s) m_sec = (m_sec + 1) % (SEC_WRAP + 1);
         else   m_min = (m_min + 1) % (MAX_MIN + 1);
      end
      nm = old;
      if (a) begin
         nm = 2;
         if (old != 2) m_blink = 0;
         else begin
            if (tb) m_blink = 1 - m_blink;
            if (pp) m_paused = 1 - m_paused;
         end
      end else if (old == 2) begin
         nm = m_paused;
      end else if (pp) begin
         nm = 1 - old;
         m_paused = nm;
      end
      if (LAP_EN) begin
         if (nm == 2) m_lap = 0;
         else if (old != 2 && lp) begin
            m_lap = 1 - m_lap;
            if (m_lap != 0) begin m_snap_min = pmin; m_snap_sec = psec; end
         end
      end
      m_mode = nm;
   endtask

   // One clock: apply inputs, advance model, sample 1 time unit after the edge.
   task automatic step(input bit tn, ta, tb, pp, a, s, r = 1'b0, lp = 1'b0);
      tick_normal = tn; tick_adjust = ta; tick_blink = tb;
      pause_pulse = pp; adj = a; sel = s; rst = r; lap_pulse = lp;
      model_step(tn, ta, tb, pp, a, s, r, lp);
      @(posedge clk);
      #1;
   endtask

   // Set MM:SS through the adjust path, then return to the prior mode.
   task automatic preload(input int mm, input int ss);
      step(0, 0, 0, 0, 1, 0);
      for (int i = 0; i < 100 && m_min != mm; i++) step(0, 1, 0, 0, 1, 0);
      for (int i = 0; i < 100 && m_sec != ss; i++) step(0, 1, 0, 0, 1, 1);
      step(0, 0, 0, 0, 0, 0);
   endtask

   // ---- scenarios ----------------------------------------------------------
   task automatic test_reset();
      step(0, 0, 0, 0, 0, 0, 1);
      step(0, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd} !== 21'h0) begin
         errors++;
         $display("FAIL reset_initial got=%h want=000000", {mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd});
      end
      preload(12, 33);
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h1234) begin
         errors++;
         $display("FAIL reset_precount got=%h want=1234", {min_bcd, sec_bcd});
      end
      step(1, 0, 0, 0, 0, 0, 1);
      checks++;
      if ({mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd} !== 21'h0) begin
         errors++;
         $display("FAIL reset_midcount got=%h want=000000", {mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd});
      end
      step(1, 1, 1, 1, 0, 0, 1);
      checks++;
      if ({mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd} !== 21'h0) begin
         errors++;
         $display("FAIL reset_hold got=%h want=000000", {mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd});
      end
   endtask

   task automatic test_count();
      logic [15:0] want [3];
      want[0] = 16'h0059; want[1] = 16'h0100; want[2] = 16'h0101;
      preload(0, 58);
      for (int i = 0; i < 3; i++) begin
         step(1, 0, 0, 0, 0, 0);
         checks++;
         if ({min_bcd, sec_bcd} !== want[i]) begin
            errors++;
            $display("FAIL count_tick%0d got=%h want=%h", i, {min_bcd, sec_bcd}, want[i]);
         end
         step(0, 0, 0, 0, 0, 0);
         checks++;
         if ({min_bcd, sec_bcd} !== want[i]) begin
            errors++;
            $display("FAIL count_hold%0d got=%h want=%h", i, {min_bcd, sec_bcd}, want[i]);
         end
      end
   endtask

   task automatic test_wrap();
      preload(59, 59);
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0000) begin
         errors++;
         $display("FAIL wrap_full got=%h want=0000", {min_bcd, sec_bcd});
      end
      preload(9, 9);
      step(1, 0, 0, 0, 0, 0);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0910) begin
         errors++;
         $display("FAIL wrap_bcd_digit got=%h want=0910", {min_bcd, sec_bcd});
      end
   endtask

   task automatic test_pause();
      preload(0, 5);
      step(1, 0, 0, 1, 0, 0);
      checks++;
      if ({mode, pause_out, min_bcd, sec_bcd} !== {2'b01, 1'b1, 16'h0006}) begin
         errors++;
         $display("FAIL pause_coincident got=%h want=%h", {mode, pause_out, min_bcd, sec_bcd}, {2'b01, 1'b1, 16'h0006});
      end
      step(1, 0, 0, 0, 0, 0);
      step(1, 1, 0, 0, 0, 0);
      step(1, 0, 0, 0, 0, 1);
      checks++;
      if ({min_bcd, sec_bcd} !== 16'h0006) begin
         errors++;
         $display("FAIL pause_hold got=%h want=0006", {min_bcd, sec_bcd});
      end
      step(0, 0, 0, 1, 0, 0);
      checks++;
      if ({mode, pause_out} !== 3'b000) begin
         errors++;
         $display("FAIL pause_resume got=%b want=000", {mode, pause_out});
      end
   endtask

   task automatic test_adjust();
      preload(0, 59);
      step(0, 0, 0, 0, 1, 1);
      step(0, 1, 0, 0, 1, 1);
      checks++;
      if ({mode, min_bcd, sec_bcd} !== {2'b10, 16'h0000}) begin
         errors++;
         $display("FAIL adj_sec_wrap got=%h want=%h", {mode, min_bcd, sec_bcd}, {2'b10, 16'h0000});
      end
      step(0, 0, 1, 0, 1, 1);
      checks++;
      if ({blank_min, blank_sec, pause_out} !== 3'b010) begin
         errors++;
         $display("FAIL adj_blink got=%b want=010", {blank_min, blank_sec, pause_out});
      end
      step(0, 0, 0, 0, 0, 1);
      checks++;
      if ({mode, blank_min, blank_sec} !== 4'b0000) begin
         errors++;
         $display("FAIL adj_exit got=%b want=0000", {mode, blank_min, blank_sec});
      end
   endtask

   task automatic test_lap();
      if (LAP_EN) begin
         preload(0, 10);
         step(0, 0, 0, 0, 0, 0, 0, 1);
         for (int i = 0; i < 5; i++) begin
            step(1, 0, 0, 0, 0, 0);
            checks++;
            if ({min_bcd, sec_bcd} !== 16'h0010) begin
               errors++;
               $display("FAIL lap_frozen%0d got=%h want=0010", i, {min_bcd, sec_bcd});
            end
         end
         step(0, 0, 0, 0, 0, 0, 0, 1);
         checks++;
         if ({min_bcd, sec_bcd} !== 16'h0015) begin
            errors++;
            $display("FAIL lap_release got=%h want=0015", {min_bcd, sec_bcd});
         end
      end
   endtask

   task automatic test_random();
      bit tn, ta, tb, pp, a, s, r, lp;
      logic [20:0] e;
      a = 0; s = 0;
      for (int i = 0; i < 600; i++) begin
         tn = ($urandom_range(0, 2) == 0);
         ta = ($urandom_range(0, 2) == 0);
         tb = ($urandom_range(0, 2) == 0);
         if ($urandom_range(0, 19) == 0) a = ~a;
         if ($urandom_range(0, 7) == 0)  s = ~s;
         // Pause presses only on cycles where adj agrees with the current mode.
         pp = ($urandom_range(0, 7) == 0) && (a == (m_mode == 2));
         lp = ($urandom_range(0, 11) == 0);
         r  = ($urandom_range(0, 249) == 0);
         step(tn, ta, tb, pp, a, s, r, lp);
         e = exp_vec();
         checks++;
         if ({mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd} !== e) begin
            errors++;
            $display("FAIL random_cycle%0d got=%h want=%h", i, {mode, pause_out, blank_min, blank_sec, min_bcd, sec_bcd}, e);
         end
      end
   endtask

   initial begin
      test_reset();
      test_count();
      test_wrap();
      test_pause();
      test_adjust();
      test_lap();
      test_random();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
